// File: rtl/spm_dma.sv
// -----------------------------------------------------------------------------
// spm_dma
// -----------------------------------------------------------------------------
// Block-copy engine acting as the initiator on port B of the scratch-pad
// memory. Software supplies a source, a destination and a word count; the
// engine then alternates a read cycle (RD) and a write cycle (WR) per word,
// copying in strictly ascending address order. Addresses wrap modulo
// 2^ADDR_W. Overlapping ranges behave as a plain word-by-word forward copy.
//
// Optional feature (compile-time macro SPM_DMA_FILL_EN):
//   adds fill_mode / fill_data. A start with fill_mode=1 latches fill_data
//   and writes it to N consecutive destination words, one per cycle, with no
//   read phase. Without the macro the block is copy-only.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        one-cycle request, honoured only while idle
//   src_addr     first source word address (copy mode)
//   dst_addr     first destination word address
//   len          word count, 0..2^ADDR_W; larger values saturate
//   abort        cancel the running transfer (no done pulse)
//   fill_mode    (SPM_DMA_FILL_EN only) select pattern-fill mode
//   fill_data    (SPM_DMA_FILL_EN only) pattern written in fill mode
//   busy         high while a transfer is in progress
//   done         one-cycle pulse on normal completion
//   spm_addr     SPM port B word address (registered)
//   spm_wr_data  SPM port B write data
//   spm_we       SPM port B write enable (registered)
//   spm_rd_data  SPM port B read data, one cycle after the address
// -----------------------------------------------------------------------------
module spm_dma #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
`ifdef SPM_DMA_FILL_EN
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] spm_addr,
    output logic [DATA_W-1:0] spm_wr_data,
    output logic              spm_we,
    input  logic [DATA_W-1:0] spm_rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    // A full-memory transfer is the largest meaningful length.
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_sat;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic              fill_q, fill_d;
`ifdef SPM_DMA_FILL_EN
    logic [DATA_W-1:0] pat_q, pat_d;
`endif

    assign len_sat = (len > MAX_LEN) ? MAX_LEN : len;

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so that busy, done, spm_addr and spm_we all come straight from flops.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        fill_d  = fill_q;
`ifdef SPM_DMA_FILL_EN
        pat_d   = pat_q;
`endif
        unique case (state_q)
            IDLE: begin
                // abort takes priority over a simultaneous start
                if (start && !abort) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_d  = src_addr;
                        dst_d  = dst_addr;
                        cnt_d  = len_sat;
                        busy_d = 1'b1;
`ifdef SPM_DMA_FILL_EN
                        if (fill_mode) begin
                            fill_d  = 1'b1;
                            pat_d   = fill_data;
                            state_d = WR;
                            addr_d  = dst_addr;
                            we_d    = 1'b1;
                        end else
`endif
                        begin
                            fill_d  = 1'b0;
                            state_d = RD;
                            addr_d  = src_addr;
                        end
                    end
                end
            end

            RD: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = WR;
                    addr_d  = dst_q;
                    we_d    = 1'b1;
                end
            end

            WR: begin
                if (abort) begin
                    // the write already on the bus lands at this edge
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    src_d = src_q + ADDR_W'(1);
                    dst_d = dst_q + ADDR_W'(1);
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (fill_q) begin
                        // fill stays in WR, one word per cycle
                        addr_d = dst_q + ADDR_W'(1);
                        we_d   = 1'b1;
                    end else begin
                        state_d = RD;
                        addr_d  = src_q + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            fill_q  <= 1'b0;
`ifdef SPM_DMA_FILL_EN
            pat_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            fill_q  <= fill_d;
`ifdef SPM_DMA_FILL_EN
            pat_q   <= pat_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign spm_addr = addr_q;
    assign spm_we   = we_q;

    // Copy mode forwards the word read in RD straight through during WR.
`ifdef SPM_DMA_FILL_EN
    assign spm_wr_data = fill_q ? pat_q : spm_rd_data;
`else
    assign spm_wr_data = spm_rd_data;
`endif

endmodule

// File: tb/tb_spm_dma.sv
module tb_spm_dma;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 13;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              abort = 1'b0;
`ifdef SPM_DMA_FILL_EN
    logic              fill_mode = 1'b0;
    logic [DATA_W-1:0] fill_data = '0;
`endif
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] spm_addr;
    logic [DATA_W-1:0] spm_wr_data;
    logic              spm_we;
    logic [DATA_W-1:0] spm_rd_data;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // SPM port B model plus preload port and write log
    logic [DATA_W-1:0] mem [0:4095];
    logic              pl_we = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;
    int                wl_cyc[$];
    logic [ADDR_W-1:0] wl_addr[$];
    logic [DATA_W-1:0] wl_data[$];

    spm_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .abort       (abort),
`ifdef SPM_DMA_FILL_EN
        .fill_mode   (fill_mode),
        .fill_data   (fill_data),
`endif
        .busy        (busy),
        .done        (done),
        .spm_addr    (spm_addr),
        .spm_wr_data (spm_wr_data),
        .spm_we      (spm_we),
        .spm_rd_data (spm_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        spm_rd_data <= mem[spm_addr];
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (spm_we) begin
            mem[spm_addr] <= spm_wr_data;
            wl_cyc.push_back(cyc);
            wl_addr.push_back(spm_addr);
            wl_data.push_back(spm_wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wl_cyc.delete();
        wl_addr.delete();
        wl_data.delete();
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    // Issues a start pulse; returns the id of the edge that samples it.
    task automatic kick(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                        input logic [LEN_W-1:0] l, output int t);
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
`ifdef SPM_DMA_FILL_EN
        fill_mode = 1'b0;
`endif
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b required 0", done); end
        n_chk++; if (spm_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b required 0", spm_we); end
        n_chk++; if (spm_addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %03h required 000", spm_addr); end
        reset = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy=%0b done=%0b required 0 0", busy, done); end
    endtask

    task automatic test_copy_basic();
        int t0;
        for (int k = 0; k < 4; k++) preload(12'h010 + 12'(k), 32'hA0 + 32'(k));
        for (int k = 0; k < 4; k++) preload(12'h100 + 12'(k), 32'h0);
        clear_log();
        kick(12'h010, 12'h100, 13'd4, t0);
        n_chk++; if (spm_addr !== 12'h010 || spm_we !== 1'b0) begin n_fail++; $display("FAIL basic_rd_phase: addr=%03h we=%0b required 010 0", spm_addr, spm_we); end
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) begin
                n_chk++; if (spm_addr !== 12'h100 || spm_we !== 1'b1) begin n_fail++; $display("FAIL basic_wr_phase: addr=%03h we=%0b required 100 1", spm_addr, spm_we); end
            end
            n_chk++;
            if (busy !== (i <= 8) || done !== (i == 9)) begin
                n_fail++; $display("FAIL basic_timing cycle %0d: busy=%0b done=%0b required %0b %0b", i, busy, done, i <= 8, i == 9);
            end
            tick();
        end
        n_chk++; if (wl_cyc.size() != 4) begin n_fail++; $display("FAIL basic_write_count: got %0d required 4", wl_cyc.size()); end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (k >= wl_cyc.size()) begin
                n_fail++; $display("FAIL basic_write%0d: missing, required edge T+%0d", k, 2*k+2);
            end else if (wl_cyc[k] != t0 + 2*k + 2 || wl_addr[k] !== 12'h100 + 12'(k) || wl_data[k] !== 32'hA0 + 32'(k)) begin
                n_fail++; $display("FAIL basic_write%0d: edge T+%0d addr=%03h data=%08h required T+%0d %03h %08h", k, wl_cyc[k] - t0, wl_addr[k], wl_data[k], 2*k+2, 12'h100 + 12'(k), 32'hA0 + 32'(k));
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (mem[12'h100 + 12'(k)] !== 32'hA0 + 32'(k)) begin n_fail++; $display("FAIL basic_mem%0d: got %08h required %08h", k, mem[12'h100 + 12'(k)], 32'hA0 + 32'(k)); end
        end
    endtask

    task automatic test_wrap();
        int t0;
        logic [ADDR_W-1:0] srcs [4];
        srcs[0] = 12'hFFE; srcs[1] = 12'hFFF; srcs[2] = 12'h000; srcs[3] = 12'h001;
        for (int k = 0; k < 4; k++) preload(srcs[k], 32'hB0 + 32'(k));
        clear_log();
        kick(12'hFFE, 12'h7FE, 13'd4, t0);
        for (int i = 0; i < 10; i++) tick();
        n_chk++; if (wl_cyc.size() != 4) begin n_fail++; $display("FAIL wrap_write_count: got %0d required 4", wl_cyc.size()); end
        for (int k = 0; k < 4 && k < wl_cyc.size(); k++) begin
            n_chk++;
            if (wl_addr[k] !== 12'h7FE + 12'(k) || wl_data[k] !== 32'hB0 + 32'(k)) begin
                n_fail++; $display("FAIL wrap_write%0d: addr=%03h data=%08h required %03h %08h", k, wl_addr[k], wl_data[k], 12'h7FE + 12'(k), 32'hB0 + 32'(k));
            end
        end
    endtask

    task automatic test_len_zero();
        int t0;
        clear_log();
        kick(12'h010, 12'h400, 13'd0, t0);
        n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL len0_cycle1: done=%0b busy=%0b required 1 0", done, busy); end
        tick();
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL len0_cycle2: done=%0b busy=%0b required 0 0", done, busy); end
        tick(); tick();
        n_chk++; if (wl_cyc.size() != 0) begin n_fail++; $display("FAIL len0_writes: got %0d required 0", wl_cyc.size()); end
    endtask

    task automatic test_overlap();
        int t0;
        preload(12'h030, 32'hD0); preload(12'h031, 32'hD1); preload(12'h032, 32'hD2);
        kick(12'h030, 12'h031, 13'd2, t0);
        for (int i = 0; i < 6; i++) tick();
        n_chk++; if (mem[12'h031] !== 32'hD0) begin n_fail++; $display("FAIL overlap_w0: got %08h required 000000d0", mem[12'h031]); end
        n_chk++; if (mem[12'h032] !== 32'hD0) begin n_fail++; $display("FAIL overlap_w1: got %08h required 000000d0", mem[12'h032]); end
    endtask

    task automatic test_abort();
        int t0;
        for (int k = 0; k < 8; k++) preload(12'h020 + 12'(k), 32'hC0 + 32'(k));
        for (int k = 0; k < 8; k++) preload(12'h300 + 12'(k), 32'h55);
        clear_log();
        kick(12'h020, 12'h300, 13'd8, t0);   // i=1: RD w0
        tick();                               // i=2: WR w0
        start = 1'b1; src_addr = 12'h040; dst_addr = 12'h500; len = 13'd1;
        tick();                               // i=3: RD w1
        start = 1'b0;
        tick(); tick();                       // i=5: RD w2
        n_chk++; if (busy !== 1'b1 || spm_addr !== 12'h022) begin n_fail++; $display("FAIL abort_pre: busy=%0b addr=%03h required 1 022", busy, spm_addr); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++; if (busy !== 1'b0 || spm_we !== 1'b0) begin n_fail++; $display("FAIL abort_stop: busy=%0b we=%0b required 0 0", busy, spm_we); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_quiet%0d: done=%0b busy=%0b required 0 0", i, done, busy); end
            tick();
        end
        n_chk++; if (wl_cyc.size() != 2) begin n_fail++; $display("FAIL abort_write_count: got %0d required 2", wl_cyc.size()); end
        for (int k = 0; k < 2 && k < wl_cyc.size(); k++) begin
            n_chk++; if (wl_addr[k] !== 12'h300 + 12'(k) || wl_data[k] !== 32'hC0 + 32'(k)) begin n_fail++; $display("FAIL abort_write%0d: addr=%03h data=%08h required %03h %08h", k, wl_addr[k], wl_data[k], 12'h300 + 12'(k), 32'hC0 + 32'(k)); end
        end
        for (int k = 2; k < 8; k++) begin
            n_chk++; if (mem[12'h300 + 12'(k)] !== 32'h55) begin n_fail++; $display("FAIL abort_untouched%0d: got %08h required 00000055", k, mem[12'h300 + 12'(k)]); end
        end
    endtask

    task automatic test_start_abort_idle();
        clear_log();
        start = 1'b1; abort = 1'b1; src_addr = 12'h010; dst_addr = 12'h480; len = 13'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL start_abort_c1: busy=%0b done=%0b required 0 0", busy, done); end
        tick(); tick(); tick(); tick();
        n_chk++; if (wl_cyc.size() != 0 || done !== 1'b0) begin n_fail++; $display("FAIL start_abort_writes: writes=%0d done=%0b required 0 0", wl_cyc.size(), done); end
    endtask

    task automatic test_reset_mid();
        int t0, t1;
        preload(12'h601, 32'h77);
        clear_log();
        kick(12'h010, 12'h600, 13'd8, t0);
        tick(); tick();                       // RD of word 1; word 0 already written
        #1 reset = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || spm_we !== 1'b0 || spm_addr !== 12'h000) begin
            n_fail++; $display("FAIL reset_async: busy=%0b done=%0b we=%0b addr=%03h required 0 0 0 000", busy, done, spm_we, spm_addr);
        end
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        n_chk++; if (wl_cyc.size() != 1) begin n_fail++; $display("FAIL reset_write_count: got %0d required 1", wl_cyc.size()); end
        n_chk++; if (mem[12'h601] !== 32'h77) begin n_fail++; $display("FAIL reset_untouched: got %08h required 00000077", mem[12'h601]); end
        clear_log();
        kick(12'h012, 12'h610, 13'd2, t1);
        for (int i = 1; i <= 6; i++) begin
            n_chk++;
            if (busy !== (i <= 4) || done !== (i == 5)) begin n_fail++; $display("FAIL reset_restart cycle %0d: busy=%0b done=%0b required %0b %0b", i, busy, done, i <= 4, i == 5); end
            tick();
        end
        n_chk++; if (mem[12'h610] !== 32'hA2 || mem[12'h611] !== 32'hA3) begin n_fail++; $display("FAIL reset_restart_data: got %08h %08h required 000000a2 000000a3", mem[12'h610], mem[12'h611]); end
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        clear_log();
        kick(12'h010, 12'h700, 13'd1, t0);
        tick(); tick();                       // done cycle
        n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done: done=%0b busy=%0b required 1 0", done, busy); end
        kick(12'h011, 12'h701, 13'd1, t1);
        n_chk++; if (busy !== 1'b1 || spm_addr !== 12'h011) begin n_fail++; $display("FAIL b2b_second_rd: busy=%0b addr=%03h required 1 011", busy, spm_addr); end
        tick(); tick(); tick();
        n_chk++; if (wl_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_write_count: got %0d required 2", wl_cyc.size()); end
        else begin
            n_chk++; if (wl_cyc[0] != t0 + 2 || wl_cyc[1] != t0 + 5) begin n_fail++; $display("FAIL b2b_edges: got T+%0d T+%0d required T+2 T+5", wl_cyc[0] - t0, wl_cyc[1] - t0); end
            n_chk++; if (wl_data[0] !== 32'hA0 || wl_data[1] !== 32'hA1) begin n_fail++; $display("FAIL b2b_data: got %08h %08h required 000000a0 000000a1", wl_data[0], wl_data[1]); end
        end
    endtask

    task automatic test_len_saturate();
        int t0;
        int busy_cnt;
        int done_at;
        clear_log();
        busy_cnt = 0;
        done_at = -1;
        kick(12'h000, 12'h000, 13'h1FFF, t0);
        for (int i = 1; i <= 9000; i++) begin
            if (busy) busy_cnt++;
            if (done) begin done_at = i; break; end
            tick();
        end
        n_chk++; if (done_at != 8193) begin n_fail++; $display("FAIL sat_done: done at cycle %0d required 8193 (-1 means timeout)", done_at); end
        n_chk++; if (busy_cnt != 8192) begin n_fail++; $display("FAIL sat_busy: got %0d required 8192", busy_cnt); end
        n_chk++; if (wl_cyc.size() != 4096) begin n_fail++; $display("FAIL sat_writes: got %0d required 4096", wl_cyc.size()); end
        tick();
    endtask

`ifdef SPM_DMA_FILL_EN
    task automatic test_fill();
        int t0;
        clear_log();
        start = 1'b1; fill_mode = 1'b1; fill_data = 32'hDEADBEEF;
        src_addr = 12'h055; dst_addr = 12'h200; len = 13'd3;
        t0 = cyc;
        tick();
        start = 1'b0; fill_mode = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            n_chk++;
            if (busy !== (i <= 3) || done !== (i == 4)) begin n_fail++; $display("FAIL fill_timing cycle %0d: busy=%0b done=%0b required %0b %0b", i, busy, done, i <= 3, i == 4); end
            tick();
        end
        n_chk++; if (wl_cyc.size() != 3) begin n_fail++; $display("FAIL fill_write_count: got %0d required 3", wl_cyc.size()); end
        for (int k = 0; k < 3 && k < wl_cyc.size(); k++) begin
            n_chk++;
            if (wl_cyc[k] != t0 + k + 1 || wl_addr[k] !== 12'h200 + 12'(k) || wl_data[k] !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL fill_write%0d: edge T+%0d addr=%03h data=%08h required T+%0d %03h deadbeef", k, wl_cyc[k] - t0, wl_addr[k], wl_data[k], k + 1, 12'h200 + 12'(k));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_copy_basic();
        test_wrap();
        test_len_zero();
        test_overlap();
        test_abort();
        test_start_abort_idle();
        test_reset_mid();
        test_back_to_back();
`ifdef SPM_DMA_FILL_EN
        test_fill();
`endif
        test_len_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spm_dma.md
# spm_dma

Block-copy engine that acts as the initiator on port B of the scratch-pad memory (SPM). It drives the SPM address, write data and write enable, and consumes the one-cycle-latency read data. Software starts it with a source, destination and length, and it moves words inside the SPM without CPU load/store traffic. It sits beside the SPM and takes port B, while port A stays with the CPU pipeline.

## Interface
- ADDR_W, 12, SPM word-address width (4096-word SPM)
- DATA_W, 32, SPM word width
- LEN_W, 13, length width; a 13-bit length covers a full 4096-word transfer

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only when busy=0
- src_addr  in  ADDR_W  first source word address (copy mode)
- dst_addr  in  ADDR_W  first destination word address
- len  in  LEN_W  word count; 0 to 4096, values above 4096 saturate to 4096
- abort  in  1  cancel the current transfer
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when a transfer completes normally
- spm_addr  out  ADDR_W  to SPM port B address
- spm_wr_data  out  DATA_W  to SPM port B write data
- spm_we  out  1  to SPM port B write enable
- spm_rd_data  in  DATA_W  from SPM port B read data; valid one cycle after the address is presented

## Operation
- States: IDLE, RD, WR.
- IDLE:
  - start=1 with len=0: stay in IDLE, pulse done next cycle, no SPM access.
  - start=1 with len>0: latch src, dst and count, then go to RD.
- RD: spm_addr=src, spm_we=0. Then go to WR.
- WR: spm_addr=dst, spm_we=1, spm_wr_data=spm_rd_data (combinational pass-through of the word read in RD).
  - Increment src and dst modulo 2^ADDR_W; wrap 4095→0 is legal.
  - Decrement count. At count 0, go to IDLE and pulse done; otherwise go to RD.
- Copy order is strictly ascending. Overlapping ranges give exact sequential word-by-word semantics: a forward overlap with dst>src replicates the source words. This is intended, and software must not rely on memmove behaviour.
- abort=1 in RD or WR: next state is IDLE, spm_we=0, busy=0, done is not pulsed. A write already asserted in the current cycle still completes at the edge.
- abort in IDLE has no effect. If start and abort are both asserted in IDLE, abort wins and the transfer does not start.
- start while busy=1 is ignored, and the latched parameters do not change.
- busy=1 exactly while the state is RD or WR.
- Reset forces IDLE with busy=0, done=0, spm_we=0, spm_addr=0 and all internal registers cleared. Reset mid-transfer abandons the transfer with no further writes.

## Timing
- All outputs are registered, except spm_wr_data in copy mode, which is a combinational pass-through of spm_rd_data in WR.
- start sampled high at edge T:
  - RD is presented after T.
  - Source word k is addressed after edge T+2k.
  - Destination word k is written at edge T+2k+2.
- Throughput is 2 cycles per word. A len=N transfer occupies 2N busy cycles.
- done is high for the single cycle after the last write edge T+2N. busy is already 0 in that cycle.
- A new start accepted in the done cycle begins RD in the following cycle, giving back-to-back transfers with no bubble beyond the done cycle.
- len=0: done is high during cycle T+1 and busy never rises.

## Configuration
- SPM_DMA_FILL_EN
  - Defined: adds input fill_mode (1) and input fill_data (DATA_W).
    - start with fill_mode=1 latches fill_data, skips RD and stays in WR for N consecutive cycles.
    - spm_wr_data is the latched pattern, registered.
    - Word k is written at edge T+k+1; done is high in the cycle after edge T+N.
    - src_addr is ignored. Copy mode is unchanged.
  - Undefined: no fill ports, and the block is copy-only.

## Test plan
- Preload SPM[0x010..0x013]=0xA0..0xA3, start src=0x010 dst=0x100 len=4 → writes at edges T+2, T+4, T+6, T+8; SPM[0x100..0x103]=0xA0..0xA3; busy high 8 cycles; done in cycle T+9.
- src=0xFFE dst=0x7FE len=4 → source addresses FFE, FFF, 000, 001 are read in order, and destinations 7FE..801 receive them.
- len=0 start → done 1 cycle later, spm_we never asserted, busy stays 0.
- Abort asserted in the RD cycle of word 2 of a len=8 copy → only words 0-1 written, busy drops next cycle, no done, SPM[dst+2..] unchanged. A second start pulse during busy is ignored.
- Reset asserted mid-transfer → outputs 0 immediately (async), no further writes, and a fresh start after release works.
- With SPM_DMA_FILL_EN: fill_mode=1 fill_data=0xDEADBEEF dst=0x200 len=3 → writes at T+1..T+3, done in cycle T+4.
